mem2_lookup_arbiter: RTL and testbench
======================================

// Module: mem2_lookup_arbiter
// PURPOSE
//  Shares one combinational 8-entry parity lookup table (index[2:0] -> data[7:0] + parity)
//  between NREQ requesters. Round-robin arbitration, drives the table index, waits for
//  settle, captures data+parity, returns a tagged response over valid/ready.
//  Optionally checks even parity and counts faults.
// PARAMETERS
//  NREQ     2  number of requesters, 2..4
//  MEM_WAIT 1  settle cycles between driving mem_index and capture, 1..7
//  ERRW     8  width of the parity-error counter
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   NREQ      request pending, one bit per requester
//  req_index  in   3*NREQ    table index; requester k uses bits [3k+2:3k]
//  req_ready  out  NREQ      one-hot accept strobe
//  mem_index  out  3         index driven to the lookup table
//  mem_data   in   8         table data, combinational from mem_index
//  mem_parity in   1         table stored parity bit
//  rsp_valid  out  1         response available
//  rsp_ready  in   1         response consumer accepts
//  rsp_data   out  8         captured table data
//  rsp_id     out  2         requester number the response belongs to
//  rsp_perr   out  1         parity mismatch on this response
//  err_count  out  ERRW      saturating count of delivered responses with rsp_perr=1
// BEHAVIOUR
//  - Reset (async on rst_n low, applies immediately):
//    state=IDLE, rr_ptr=0, wait counter=0. All outputs 0: req_ready, mem_index,
//    rsp_valid, rsp_data, rsp_id, rsp_perr, err_count. An in-flight request is dropped.
//  - FSM states and transitions:
//    IDLE:   if any req_valid, grant the first set bit searching from rr_ptr upward,
//            wrapping mod NREQ. req_ready[g]=1 combinationally in that cycle only.
//            At the edge: latch index and id, go to LOOKUP. No req_valid: stay in IDLE.
//    LOOKUP: mem_index = latched index, held stable. Counts MEM_WAIT cycles.
//            On the edge ending the last cycle, capture mem_data, mem_parity and perr
//            into the rsp registers, then go to RESP.
//    RESP:   rsp_valid=1. rsp_data, rsp_id and rsp_perr stay stable until the handshake.
//            On rsp_valid & rsp_ready: go to IDLE, rsp_valid=0 next cycle,
//            rr_ptr = (g+1) mod NREQ.
//  - req_ready is 0 in LOOKUP and RESP. There is only one outstanding request.
//  - Latency: accept at edge E0 -> rsp_valid high after edge E0+MEM_WAIT.
//    Minimum per-transaction period is MEM_WAIT+2 cycles.
//  - Requesters hold req_valid and req_index until req_ready. Dropping req_valid
//    before grant is legal and withdraws the request. Arbitration uses current
//    req_valid only.
//  - mem_index keeps its last value in IDLE and RESP. After reset it is 0.
//  - Parity rule: perr = (^mem_data) ^ mem_parity (even parity over the 9 bits).
//  - err_count increments at the rsp handshake when rsp_perr=1.
//    It saturates at 2^ERRW-1 and never wraps.
//  - Unused rsp_id upper bits are 0 when NREQ<=2.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//    perr computed as above. rsp_perr and err_count are live.
//  PARITY_CHECK_EN undefined:
//    no parity logic. rsp_perr and err_count are tied to 0.
//    mem_parity is ignored. Data path and timing are unchanged.
// TESTING (table model: data(i)={i,1'b0,i,1'b0}, parity 0)
//  1 req0 index 3, rsp_ready=1 -> req_ready[0] 1 cycle; rsp_valid after E0+MEM_WAIT;
//    rsp_data=8'h66, rsp_id=0, rsp_perr=0.
//  2 req0 idx5 and req1 idx2 both held continuously -> grants alternate 0,1,0,1;
//    rsp_data 8'hAA (id0) and 8'h44 (id1) alternate.
//  3 rsp_ready low 5 cycles during RESP -> rsp_valid/data/id held; req_ready stays 0;
//    release -> IDLE next cycle.
//  4 model forces mem_parity=1 for idx1 -> rsp_data=8'h22, rsp_perr=1, err_count=1
//    with PARITY_CHECK_EN; rsp_perr=0, err_count=0 without.
//  5 rst_n low mid-LOOKUP -> all outputs 0 immediately; after release req1 idx7 ->
//    rsp_data=8'hEE, rsp_id=1.
//  6 ERRW=2, 5 consecutive parity faults -> err_count 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/mem2_lookup_arbiter_if.sv
// ============================================================================
// Module   : mem2_lookup_arbiter_if
// Brief    : Request, lookup-table and response bundle for mem2_lookup_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem2_lookup_arbiter_if #(
    parameter int NREQ = 2,
    parameter int ERRW = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_index;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        mem_index;
    logic [7:0]        mem_data;
    logic              mem_parity;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_perr;
    logic [ERRW-1:0]   err_count;

    // Arbiter side
    modport slave (
        input  req_valid, req_index, mem_data, mem_parity, rsp_ready,
        output req_ready, mem_index, rsp_valid, rsp_data, rsp_id, rsp_perr, err_count
    );

    // Requester / table / consumer side
    modport master (
        output req_valid, req_index, mem_data, mem_parity, rsp_ready,
        input  req_ready, mem_index, rsp_valid, rsp_data, rsp_id, rsp_perr, err_count
    );
endinterface

`default_nettype wire

// File: rtl/mem2_lookup_arbiter.sv
// ============================================================================
// Module   : mem2_lookup_arbiter
// Brief    : Round-robin shares one combinational 8-entry lookup table among
//            NREQ requesters; define PARITY_CHECK_EN for parity check/counting.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem2_lookup_arbiter #(
    parameter int NREQ     = 2,
    parameter int MEM_WAIT = 1,
    parameter int ERRW     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem2_lookup_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] c_last_wait = 3'(MEM_WAIT - 1);
    localparam logic [1:0] c_last_req  = 2'(NREQ - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_rr_ptr;
    logic [1:0]      r_id;
    logic [2:0]      r_idx;
    logic [2:0]      r_wait;
    logic [7:0]      r_rsp_data;
    logic [1:0]      r_rsp_id;
    logic            w_gnt_found;
    logic [1:0]      w_gnt_id;
    logic [2:0]      w_gnt_index;
    logic [2:0]      w_cand;
    logic [NREQ-1:0] w_req_ready;
    logic            w_accept;
    logic            w_capture;
    logic            w_rsp_hs;

    // Search from r_rr_ptr upward, wrapping, for the first pending requester.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = 2'd0;
        w_gnt_index = 3'd0;
        w_cand      = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_rr_ptr} + 3'(i);
            if (w_cand >= 3'(NREQ)) begin
                w_cand = w_cand - 3'(NREQ);
            end
            for (int k = 0; k < NREQ; k++) begin
                if (!w_gnt_found && (w_cand == 3'(k)) && bus.req_valid[k]) begin
                    w_gnt_found = 1'b1;
                    w_gnt_id    = 2'(k);
                    w_gnt_index = bus.req_index[3*k +: 3];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_hs    = 1'b0;
        w_req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOOKUP;
                    for (int k = 0; k < NREQ; k++) begin
                        w_req_ready[k] = (w_gnt_id == 2'(k));
                    end
                end
            end
            S_LOOKUP: begin
                if (r_wait == c_last_wait) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_idx drives the table directly, so mem_index holds between lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 2'd0;
            r_id       <= 2'd0;
            r_idx      <= 3'd0;
            r_wait     <= 3'd0;
            r_rsp_data <= 8'd0;
            r_rsp_id   <= 2'd0;
        end else begin
            if (w_accept) begin
                r_id   <= w_gnt_id;
                r_idx  <= w_gnt_index;
                r_wait <= 3'd0;
            end else if (r_state == S_LOOKUP && !w_capture) begin
                r_wait <= r_wait + 3'd1;
            end
            if (w_capture) begin
                r_rsp_data <= bus.mem_data;
                r_rsp_id   <= r_id;
            end
            if (w_rsp_hs) begin
                r_rr_ptr <= (r_id == c_last_req) ? 2'd0 : r_id + 2'd1;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic            w_perr;
    logic            r_rsp_perr;
    logic [ERRW-1:0] r_err_cnt;

    assign w_perr = (^bus.mem_data) ^ bus.mem_parity;

    // Counter saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_perr <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_rsp_perr <= w_perr;
            end
            if (w_rsp_hs && r_rsp_perr && (r_err_cnt != {ERRW{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

    assign bus.rsp_perr  = r_rsp_perr;
    assign bus.err_count = r_err_cnt;
`else
    logic w_unused_parity;
    assign w_unused_parity = bus.mem_parity;
    assign bus.rsp_perr    = 1'b0;
    assign bus.err_count   = '0;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.mem_index = r_idx;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_mem2_lookup_arbiter.sv
// ============================================================================
// Module   : tb_mem2_lookup_arbiter
// Brief    : Directed self-checking bench for mem2_lookup_arbiter (NREQ=2,
//            MEM_WAIT=3, ERRW=2); expectations follow PARITY_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem2_lookup_arbiter;

    localparam int NREQ     = 2;
    localparam int MEM_WAIT = 3;
    localparam int ERRW     = 2;
`ifdef PARITY_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic clk;
    logic rst_n;
    bit   force_par;
    int   n_cmp;
    int   n_err;

    mem2_lookup_arbiter_if #(.NREQ(NREQ), .ERRW(ERRW)) bus ();

    mem2_lookup_arbiter #(.NREQ(NREQ), .MEM_WAIT(MEM_WAIT), .ERRW(ERRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table model: data(i) = {i,0,i,0}, parity 0 unless a fault is injected on idx1
    always_comb begin
        bus.mem_data   = {bus.mem_index, 1'b0, bus.mem_index, 1'b0};
        bus.mem_parity = force_par && (bus.mem_index == 3'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        force_par     = 1'b0;
        bus.req_valid = '0;
        bus.req_index = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
        n_cmp++; if (bus.mem_index !== 3'd0) begin n_err++; $display("FAIL rst_mem_index got=%0d exp=0", bus.mem_index); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got=%h exp=00", bus.rsp_data); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL rst_rsp_id got=%0d exp=0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_perr !== 1'b0) begin n_err++; $display("FAIL rst_rsp_perr got=%b exp=0", bus.rsp_perr); end
        n_cmp++; if (bus.err_count !== 2'd0) begin n_err++; $display("FAIL rst_err_count got=%0d exp=0", bus.err_count); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL idle_req_ready got=%b exp=00", bus.req_ready); end
    endtask

    task automatic test_single();
        bus.req_index = {3'd0, 3'd3};
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL t1_grant got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        for (int k = 0; k < MEM_WAIT; k++) begin
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid cyc=%0d got=%b exp=0", k, bus.rsp_valid); end
            n_cmp++; if (bus.mem_index !== 3'd3) begin n_err++; $display("FAIL t1_mem_index cyc=%0d got=%0d exp=3", k, bus.mem_index); end
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL t1_lookup_ready cyc=%0d got=%b exp=00", k, bus.req_ready); end
            tick();
        end
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got=%b exp=1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 8'h66) begin n_err++; $display("FAIL t1_data got=%h exp=66", bus.rsp_data); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL t1_id got=%0d exp=0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_perr !== 1'b0) begin n_err++; $display("FAIL t1_perr got=%b exp=0", bus.rsp_perr); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_drop got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.mem_index !== 3'd3) begin n_err++; $display("FAIL t1_index_hold got=%0d exp=3", bus.mem_index); end
    endtask

    task automatic test_round_robin();
        bit         ok;
        logic [1:0] exp_rdy;
        logic [7:0] exp_data;
        apply_reset();
        bus.req_index = {3'd2, 3'd5};
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 4; t++) begin
            exp_rdy  = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (t % 2 == 0) ? 8'hAA : 8'h44;
            n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL t2_grant n=%0d got=%b exp=%b", t, bus.req_ready, exp_rdy); end
            tick();
            wait_rsp(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL t2_timeout n=%0d got=no_rsp exp=rsp_valid", t); end
            n_cmp++; if (bus.rsp_data !== exp_data) begin n_err++; $display("FAIL t2_data n=%0d got=%h exp=%h", t, bus.rsp_data, exp_data); end
            n_cmp++; if (bus.rsp_id !== 2'(t % 2)) begin n_err++; $display("FAIL t2_id n=%0d got=%0d exp=%0d", t, bus.rsp_id, t % 2); end
            tick();
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        bit ok;
        bus.req_index = {3'd6, 3'd4};
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL t3_grant got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b10;
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL t3_timeout got=no_rsp exp=rsp_valid"); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL t3_hold_valid cyc=%0d got=%b exp=1", k, bus.rsp_valid); end
            n_cmp++; if (bus.rsp_data !== 8'h88) begin n_err++; $display("FAIL t3_hold_data cyc=%0d got=%h exp=88", k, bus.rsp_data); end
            n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL t3_hold_id cyc=%0d got=%0d exp=0", k, bus.rsp_id); end
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL t3_hold_ready cyc=%0d got=%b exp=00", k, bus.req_ready); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t3_release got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL t3_next_grant got=%b exp=10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(ok);
        n_cmp++; if (bus.rsp_data !== 8'hCC) begin n_err++; $display("FAIL t3_data2 got=%h exp=cc", bus.rsp_data); end
        n_cmp++; if (bus.rsp_id !== 2'd1) begin n_err++; $display("FAIL t3_id2 got=%0d exp=1", bus.rsp_id); end
        tick();
    endtask

    task automatic test_parity();
        bit ok;
        force_par     = 1'b1;
        bus.req_index = {3'd0, 3'd1};
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL t4_timeout got=no_rsp exp=rsp_valid"); end
        n_cmp++; if (bus.rsp_data !== 8'h22) begin n_err++; $display("FAIL t4_data got=%h exp=22", bus.rsp_data); end
        n_cmp++; if (bus.rsp_perr !== PC) begin n_err++; $display("FAIL t4_perr got=%b exp=%b", bus.rsp_perr, PC); end
        n_cmp++; if (bus.err_count !== 2'd0) begin n_err++; $display("FAIL t4_cnt_pre got=%0d exp=0", bus.err_count); end
        tick();
        n_cmp++; if (bus.err_count !== 2'(PC)) begin n_err++; $display("FAIL t4_cnt got=%0d exp=%0d", bus.err_count, PC); end
        force_par = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        bus.req_index = {3'd0, 3'd3};
        bus.req_valid = 2'b01;
        #1;
        tick();
        bus.req_valid = 2'b00;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL t5_req_ready got=%b exp=00", bus.req_ready); end
        n_cmp++; if (bus.mem_index !== 3'd0) begin n_err++; $display("FAIL t5_mem_index got=%0d exp=0", bus.mem_index); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t5_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 8'h00) begin n_err++; $display("FAIL t5_rsp_data got=%h exp=00", bus.rsp_data); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL t5_rsp_id got=%0d exp=0", bus.rsp_id); end
        n_cmp++; if (bus.err_count !== 2'd0) begin n_err++; $display("FAIL t5_err_count got=%0d exp=0", bus.err_count); end
        tick();
        tick();
        rst_n         = 1'b1;
        bus.req_index = {3'd7, 3'd0};
        bus.req_valid = 2'b10;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL t5_grant got=%b exp=10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL t5_timeout got=no_rsp exp=rsp_valid"); end
        n_cmp++; if (bus.rsp_data !== 8'hEE) begin n_err++; $display("FAIL t5_data got=%h exp=ee", bus.rsp_data); end
        n_cmp++; if (bus.rsp_id !== 2'd1) begin n_err++; $display("FAIL t5_id got=%0d exp=1", bus.rsp_id); end
        tick();
    endtask

    task automatic test_err_saturate();
        bit ok;
        int exp;
        force_par     = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.req_index = {3'd0, 3'd1};
            bus.req_valid = 2'b01;
            #1;
            tick();
            bus.req_valid = 2'b00;
            wait_rsp(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL t6_timeout n=%0d got=no_rsp exp=rsp_valid", k); end
            tick();
            exp = PC ? ((k < 3) ? k : 3) : 0;
            n_cmp++; if (bus.err_count !== 2'(exp)) begin n_err++; $display("FAIL t6_cnt n=%0d got=%0d exp=%0d", k, bus.err_count, exp); end
        end
        force_par = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_parity();
        test_async_reset();
        test_err_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
